// File: rtl/node_route_sequencer.sv
// Route sequencer: debounces node detects, walks a programmable turn table over two laps
// and drives the motor turn block through a req/done handshake.
module node_route_sequencer #(
  parameter int ROUTE_LEN    = 14,
  parameter int LAP2_START   = 2,
  parameter int DEBOUNCE     = 4,
  parameter int TURN_TIMEOUT = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       node_det,
  input  logic       route_we,
  input  logic [3:0] route_addr,
  input  logic [1:0] route_data,
  output logic       turn_req,
  output logic [1:0] turn_cmd,
  input  logic       turn_done,
  output logic [3:0] node_idx,
  output logic       lap,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       missed_node
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TURN_TIMEOUT + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
  localparam logic [TW-1:0] TO_LAST  = TW'(TURN_TIMEOUT - 1);
  localparam logic [3:0]    LAST_IDX = 4'(ROUTE_LEN - 1);
  localparam logic [3:0]    LAP2_IDX = 4'(LAP2_START);
  localparam logic [4:0]    TBL_LEN  = 5'(ROUTE_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_ISSUE, S_WAIT_DONE, S_FINISH, S_FAULT
  } state_t;

  state_t          state;
  logic            det_s1, det_s2;
  logic [DW-1:0]   deb_cnt;
  logic            node_event;
  logic [TW-1:0]   to_cnt;
  logic [1:0]      cmd_r;
  logic [1:0]      route_tbl [16];
  logic [3:0]      adv_idx;
  logic            adv_lap;
  logic            adv_finish;
  logic            tbl_open;

  // Counter saturates at DEBOUNCE so a held level fires once until det_s2 drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_s1     <= 1'b0;
      det_s2     <= 1'b0;
      deb_cnt    <= '0;
      node_event <= 1'b0;
    end else begin
      det_s1     <= node_det;
      det_s2     <= det_s1;
      node_event <= 1'b0;
      if (!det_s2) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt    <= deb_cnt + 1'b1;
        node_event <= (deb_cnt == DEB_MAX - 1'b1);
      end
    end
  end

  // Table contents deliberately survive reset.
  assign tbl_open = (state == S_IDLE) || (state == S_FINISH);

  always_ff @(posedge clk) begin
    if (route_we && tbl_open && ({1'b0, route_addr} < TBL_LEN))
      route_tbl[route_addr] <= route_data;
  end

  always_comb begin
    adv_idx    = node_idx;
    adv_lap    = lap;
    adv_finish = 1'b0;
    if (node_idx < LAST_IDX) begin
      adv_idx = node_idx + 4'd1;
    end else if (!lap) begin
      adv_idx = LAP2_IDX;
      adv_lap = 1'b1;
    end else begin
      adv_finish = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      turn_req    <= 1'b0;
      turn_cmd    <= 2'b00;
      cmd_r       <= 2'b00;
      node_idx    <= 4'd0;
      lap         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      missed_node <= 1'b0;
      to_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            state       <= S_RUN;
            node_idx    <= 4'd0;
            lap         <= 1'b0;
            missed_node <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        S_RUN: begin
          if (node_event) begin
            case (route_tbl[node_idx])
              2'b00: begin
                if (adv_finish) begin
                  state <= S_FINISH;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  node_idx <= adv_idx;
                  lap      <= adv_lap;
                end
              end
              2'b11: begin
                state <= S_FINISH;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
              default: begin
                cmd_r <= route_tbl[node_idx];
                state <= S_ISSUE;
              end
            endcase
          end
        end
        S_ISSUE: begin
          turn_req <= 1'b1;
          turn_cmd <= cmd_r;
          to_cnt   <= '0;
          state    <= S_WAIT_DONE;
          if (node_event) missed_node <= 1'b1;
        end
        S_WAIT_DONE: begin
          if (node_event) missed_node <= 1'b1;
          // turn_done on the final timeout cycle still completes the turn.
          if (turn_done) begin
            turn_req <= 1'b0;
            if (adv_finish) begin
              state <= S_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              node_idx <= adv_idx;
              lap      <= adv_lap;
              state    <= S_RUN;
            end
          end else if (to_cnt == TO_LAST) begin
            turn_req <= 1'b0;
            fault    <= 1'b1;
            state    <= S_FAULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_FAULT: begin
          turn_req <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_node_route_sequencer.sv
// Directed bench for node_route_sequencer; expected turn commands flow through a scoreboard queue.
module tb_node_route_sequencer;
  localparam int ROUTE_LEN    = 14;
  localparam int LAP2_START   = 2;
  localparam int DEBOUNCE     = 4;
  localparam int TURN_TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       node_det = 1'b0;
  logic       route_we = 1'b0;
  logic [3:0] route_addr = 4'd0;
  logic [1:0] route_data = 2'b00;
  logic       turn_done = 1'b0;
  logic       turn_req;
  logic [1:0] turn_cmd;
  logic [3:0] node_idx;
  logic       lap, busy, done, fault, missed_node;

  int n_chk = 0;
  int n_pass = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  logic [1:0] exp_cmd_q [$];

  always #5 clk = ~clk;

  node_route_sequencer #(
    .ROUTE_LEN(ROUTE_LEN), .LAP2_START(LAP2_START),
    .DEBOUNCE(DEBOUNCE), .TURN_TIMEOUT(TURN_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .node_det(node_det),
    .route_we(route_we), .route_addr(route_addr), .route_data(route_data),
    .turn_req(turn_req), .turn_cmd(turn_cmd), .turn_done(turn_done),
    .node_idx(node_idx), .lap(lap), .busy(busy), .done(done),
    .fault(fault), .missed_node(missed_node)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Each new turn request must match the oldest expected command.
  always @(negedge clk) begin
    if (turn_req === 1'b1 && req_prev !== 1'b1) begin
      req_rises++;
      chk("sb_has_entry", 32'(exp_cmd_q.size() > 0), 1);
      if (exp_cmd_q.size() > 0) chk("turn_cmd", 32'(turn_cmd), 32'(exp_cmd_q.pop_front()));
    end
    req_prev = turn_req;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [1:0] data);
    route_we   = 1'b1;
    route_addr = 4'(addr);
    route_data = data;
    tick(1);
    route_we   = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_node(input int len);
    node_det = 1'b1;
    tick(len);
    node_det = 1'b0;
    tick(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rises0;
    logic [3:0] m_idx;
    logic m_lap;
    logic m_fin;

    // Reset and first turn
    do_reset();
    chk("reset_outputs", {turn_req, turn_cmd, busy, done, fault, missed_node, lap, node_idx}, 0);
    for (int a = 0; a < 16; a++) wr(a, (a == 3) ? 2'b01 : 2'b00);
    start_pulse();
    chk("start_busy", {busy, done, node_idx}, {2'b10, 4'd0});
    for (int i = 0; i < 3; i++) pulse_node(6);
    chk("idx_before_turn", node_idx, 3);
    exp_cmd_q.push_back(2'b01);
    node_det = 1'b1;
    cyc = 0;
    while (turn_req !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 6) node_det = 1'b0;
    end
    node_det = 1'b0;
    chk("req_latency", cyc, 2 + DEBOUNCE + 2);
    tick(10);
    chk("req_held", {turn_req, turn_cmd}, 3'b101);
    turn_done = 1'b1;
    tick(1);
    turn_done = 1'b0;
    chk("req_drop", turn_req, 0);
    chk("idx_after_turn", node_idx, 4);

    // Two laps over an all-straight table
    do_reset();
    for (int a = 0; a < 16; a++) wr(a, 2'b00);
    start_pulse();
    m_idx = 4'd0; m_lap = 1'b0; m_fin = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      pulse_node(6);
      if (!m_fin) begin
        if (m_idx < 4'(ROUTE_LEN - 1)) m_idx = m_idx + 4'd1;
        else if (!m_lap) begin m_idx = 4'(LAP2_START); m_lap = 1'b1; end
        else m_fin = 1'b1;
      end
      if (i == 14) chk("lap2_wrap", {lap, node_idx}, {1'b1, 4'd2});
      if (i < 26) chk("walk_idx_lap", {lap, node_idx}, {m_lap, m_idx});
    end
    chk("laps_finish", {done, busy}, 2'b10);

    // Debounce: short glitch ignored, long hold counts once
    start_pulse();
    chk("restart_from_finish", {busy, done, lap, node_idx}, {1'b1, 1'b0, 1'b0, 4'd0});
    pulse_node(DEBOUNCE - 1);
    chk("glitch_ignored", node_idx, 0);
    pulse_node(20);
    chk("long_hold_once", node_idx, 1);

    // Turn timeout
    do_reset();
    wr(0, 2'b10);
    start_pulse();
    exp_cmd_q.push_back(2'b10);
    node_det = 1'b1;
    cyc = 0;
    while (turn_req !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 6) node_det = 1'b0;
    end
    node_det = 1'b0;
    chk("to_req_seen", turn_req, 1);
    cyc = 0;
    while (fault !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_cycles", cyc, TURN_TIMEOUT);
    chk("fault_outputs", {fault, turn_req, busy, done}, 4'b1010);
    start_pulse();
    tick(2);
    chk("fault_ignores_start", {fault, busy, done, node_idx}, {3'b110, 4'd0});
    do_reset();
    chk("fault_cleared", {fault, busy, turn_req}, 0);

    // STOP entry and table lock during a run
    wr(0, 2'b00);
    wr(5, 2'b11);
    start_pulse();
    rises0 = req_rises;
    pulse_node(6);
    pulse_node(6);
    wr(2, 2'b01);
    for (int i = 0; i < 3; i++) pulse_node(6);
    chk("before_stop", {done, node_idx}, {1'b0, 4'd5});
    pulse_node(6);
    chk("stop_finish", {done, busy}, 2'b10);
    chk("stop_no_req", req_rises, rises0);
    start_pulse();
    for (int i = 0; i < 3; i++) pulse_node(6);
    chk("locked_write_ignored", {turn_req, node_idx}, {1'b0, 4'd3});

    // Missed node during a turn, then reset mid-turn
    do_reset();
    wr(5, 2'b00);
    wr(0, 2'b01);
    start_pulse();
    exp_cmd_q.push_back(2'b01);
    pulse_node(6);
    chk("mn_req_up", turn_req, 1);
    pulse_node(6);
    chk("missed_set", {missed_node, turn_req, node_idx}, {2'b11, 4'd0});
    turn_done = 1'b1;
    tick(1);
    turn_done = 1'b0;
    chk("missed_advance", {missed_node, turn_req, node_idx}, {2'b10, 4'd1});
    do_reset();
    start_pulse();
    exp_cmd_q.push_back(2'b01);
    pulse_node(6);
    chk("rst_req_up", turn_req, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_drops_req", {turn_req, busy, done, missed_node}, 0);
    rst = 1'b0;
    tick(2);
    chk("rst_idle", {busy, done, turn_req}, 0);

    chk("sb_drained", exp_cmd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
